// File: rtl/rtc_tick_gen_if.sv
// Configuration handshake bundle for rtc_tick_gen.
//   cfg_valid_i   : a new half-period is offered (master -> slave)
//   half_period_i : offered half-period in clk cycles (master -> slave)
//   cfg_ready_o   : slave can accept a half-period (slave -> master)
interface rtc_tick_gen_if #(
    parameter int unsigned DIV_W = 16
);
    logic             cfg_valid_i;
    logic [DIV_W-1:0] half_period_i;
    logic             cfg_ready_o;

    modport master (
        output cfg_valid_i,
        output half_period_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  half_period_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/rtc_tick_gen.sv
// Programmable RTC tick source: divides clk_i into a 50% square wave rtc_o
// with half-period hp, plus a one-cycle tick per rising edge of rtc_o.
// Half-period changes are staged and applied only at a falling toggle.
// Start/stop never shortens a high phase.
//   clk_i        : system clock
//   arst_ni      : synchronous active-low reset
//   run_i        : level request to run the divider
//   cfg          : half-period handshake (slave side)
//   rtc_o        : divided clock, low phase first
//   tick_o       : pulse in the cycle after each rtc_o rise
//   tick_count_o : count of rtc_o rising edges, wraps silently
//   running_o    : state machine is not stopped
module rtc_tick_gen #(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned DEFAULT_HALF = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             run_i,
    rtc_tick_gen_if.slave    cfg,
    output logic             rtc_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] tick_count_o,
    output logic             running_o
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             rtc_q, rtc_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] tick_count_q, tick_count_d;
    logic             running_q, running_d;

    logic             accept;
    logic [DIV_W-1:0] in_clamped;
    logic             at_edge;
    logic             fall_edge;
    logic             rise_edge;
    logic             stop_now;

    // Handshake: ready only while no value is staged.
    assign cfg.cfg_ready_o = ~pend_q;
    assign accept          = cfg.cfg_valid_i & ~pend_q;
    // A zero half-period would never toggle; store it as 1.
    assign in_clamped      = (cfg.half_period_i == '0) ? DIV_W'(1) : cfg.half_period_i;
    assign at_edge         = (cnt_q == (hp_q - DIV_W'(1)));
    assign fall_edge       = at_edge & rtc_q;
    assign rise_edge       = at_edge & ~rtc_q;

    // Next-state and output computation.
    always_comb begin
        state_d      = state_q;
        hp_d         = hp_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_val_d   = pend_val_q;
        rtc_d        = rtc_q;
        tick_d       = 1'b0;
        tick_count_d = tick_count_q;
        stop_now     = 1'b0;

        unique case (state_q)
            ST_STOP: begin
                rtc_d  = 1'b0;
                cnt_d  = '0;
                pend_d = 1'b0;
                if (accept) begin
                    hp_d = in_clamped;
                end
                if (run_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_DRAIN: begin
                if (at_edge) begin
                    cnt_d = '0;
                    rtc_d = ~rtc_q;
                    if (rise_edge) begin
                        tick_d       = 1'b1;
                        tick_count_d = tick_count_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end

                // Staged value lands at the end of a full period.
                if (fall_edge && pend_q) begin
                    hp_d   = pend_val_q;
                    pend_d = 1'b0;
                end
                if (accept) begin
                    pend_val_d = in_clamped;
                    pend_d     = 1'b1;
                end

                // Stop only from a low phase or at the end of a high phase.
                if (run_i) begin
                    state_d = ST_RUN;
                end else if (!rtc_q || fall_edge) begin
                    stop_now = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end

                if (stop_now) begin
                    state_d      = ST_STOP;
                    rtc_d        = 1'b0;
                    cnt_d        = '0;
                    tick_d       = 1'b0;
                    tick_count_d = tick_count_q;
                    pend_d       = 1'b0;
                    if (accept) begin
                        hp_d = in_clamped;
                    end else if (pend_q) begin
                        hp_d = pend_val_q;
                    end
                end
            end

            default: begin
                state_d = ST_STOP;
                rtc_d   = 1'b0;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase

        running_d = (state_d != ST_STOP);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q      <= ST_STOP;
            hp_q         <= DIV_W'(DEFAULT_HALF);
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_val_q   <= '0;
            rtc_q        <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_val_q   <= pend_val_d;
            rtc_q        <= rtc_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            running_q    <= running_d;
        end
    end

    assign rtc_o        = rtc_q;
    assign tick_o       = tick_q;
    assign tick_count_o = tick_count_q;
    assign running_o    = running_q;

endmodule

// File: tb/tb_rtc_tick_gen.sv
// Directed bench for rtc_tick_gen. Edge e is the e-th rising clk edge after
// run_i is first sampled high; outputs are sampled 1 time unit after edges.
module tb_rtc_tick_gen;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             run;
    logic             rtc;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] tick_count;

    int vectors     = 0;
    int miscompares = 0;

    rtc_tick_gen_if #(.DIV_W(DIV_W)) cfg_if ();

    rtc_tick_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_HALF(8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .run_i       (run),
        .cfg         (cfg_if),
        .rtc_o       (rtc),
        .tick_o      (tick),
        .tick_count_o(tick_count),
        .running_o   (running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        arst_n                = 1'b0;
        run                   = 1'b0;
        cfg_if.cfg_valid_i    = 1'b0;
        cfg_if.half_period_i  = '0;
        step();
        arst_n = 1'b1;
    endtask

    task automatic config_in_stop(input logic [DIV_W-1:0] v);
        cfg_if.cfg_valid_i   = 1'b1;
        cfg_if.half_period_i = v;
        step();
        cfg_if.cfg_valid_i   = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (rtc !== 1'b0) begin miscompares++; $display("FAIL reset rtc: got %b expected 0", rtc); end
        vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset tick: got %b expected 0", tick); end
        vectors++; if (tick_count !== 4'd0) begin miscompares++; $display("FAIL reset count: got %0d expected 0", tick_count); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset running: got %b expected 0", running); end
        vectors++; if (cfg_if.cfg_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset ready: got %b expected 1", cfg_if.cfg_ready_o); end
    endtask

    // Default hp=8: rises at 8, 24, 40.
    task automatic test_start();
        logic exp_rtc, exp_tick;
        apply_reset();
        run = 1'b1;
        for (int e = 0; e <= 41; e++) begin
            step();
            exp_rtc  = ((e / 8) % 2) == 1;
            exp_tick = (e >= 8) && ((e % 16) == 8);
            vectors++; if (rtc !== exp_rtc) begin miscompares++; $display("FAIL start rtc e=%0d: got %b expected %b", e, rtc, exp_rtc); end
            vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL start tick e=%0d: got %b expected %b", e, tick, exp_tick); end
            vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL start running e=%0d: got %b expected 1", e, running); end
        end
        vectors++; if (tick_count !== 4'd3) begin miscompares++; $display("FAIL start count: got %0d expected 3", tick_count); end
    endtask

    // hp=4, offer 6 at edge 10; applied at fall edge 16; low 16..21, high 22..27.
    task automatic test_cfg_change();
        logic exp_rtc, exp_ready, exp_tick;
        apply_reset();
        config_in_stop(16'd4);
        vectors++; if (cfg_if.cfg_ready_o !== 1'b1) begin miscompares++; $display("FAIL cfg stop ready: got %b expected 1", cfg_if.cfg_ready_o); end
        run = 1'b1;
        for (int e = 0; e <= 29; e++) begin
            cfg_if.cfg_valid_i   = (e == 10);
            cfg_if.half_period_i = 16'd6;
            step();
            if (e < 16)      exp_rtc = ((e / 4) % 2) == 1;
            else if (e < 22) exp_rtc = 1'b0;
            else if (e < 28) exp_rtc = 1'b1;
            else             exp_rtc = 1'b0;
            exp_ready = !((e >= 10) && (e < 16));
            exp_tick  = (e == 4) || (e == 12) || (e == 22);
            vectors++; if (rtc !== exp_rtc) begin miscompares++; $display("FAIL cfg rtc e=%0d: got %b expected %b", e, rtc, exp_rtc); end
            vectors++; if (cfg_if.cfg_ready_o !== exp_ready) begin miscompares++; $display("FAIL cfg ready e=%0d: got %b expected %b", e, cfg_if.cfg_ready_o, exp_ready); end
            vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL cfg tick e=%0d: got %b expected %b", e, tick, exp_tick); end
        end
        cfg_if.cfg_valid_i = 1'b0;
    endtask

    // hp=5, drop run at edge 17 (high phase 15..19): fall and stop at edge 20.
    task automatic test_drain_stop();
        logic exp_rtc, exp_run;
        apply_reset();
        config_in_stop(16'd5);
        run = 1'b1;
        for (int e = 0; e <= 25; e++) begin
            run = (e < 17);
            step();
            exp_rtc = (e < 20) ? (((e / 5) % 2) == 1) : 1'b0;
            exp_run = (e < 20);
            vectors++; if (rtc !== exp_rtc) begin miscompares++; $display("FAIL drain rtc e=%0d: got %b expected %b", e, rtc, exp_rtc); end
            vectors++; if (running !== exp_run) begin miscompares++; $display("FAIL drain running e=%0d: got %b expected %b", e, running, exp_run); end
        end
    endtask

    // hp=5, run low at edges 16,17 then high again: period undisturbed.
    task automatic test_drain_resume();
        logic exp_rtc;
        apply_reset();
        config_in_stop(16'd5);
        for (int e = 0; e <= 31; e++) begin
            run = !((e == 16) || (e == 17));
            step();
            exp_rtc = ((e / 5) % 2) == 1;
            vectors++; if (rtc !== exp_rtc) begin miscompares++; $display("FAIL resume rtc e=%0d: got %b expected %b", e, rtc, exp_rtc); end
            vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL resume running e=%0d: got %b expected 1", e, running); end
        end
    endtask

    // Zero clamps to 1: rtc toggles every edge, tick on odd edges.
    task automatic test_clamp();
        logic exp_rtc;
        apply_reset();
        config_in_stop(16'd0);
        vectors++; if (cfg_if.cfg_ready_o !== 1'b1) begin miscompares++; $display("FAIL clamp ready: got %b expected 1", cfg_if.cfg_ready_o); end
        run = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            step();
            exp_rtc = (e % 2) == 1;
            vectors++; if (rtc !== exp_rtc) begin miscompares++; $display("FAIL clamp rtc e=%0d: got %b expected %b", e, rtc, exp_rtc); end
            vectors++; if (tick !== exp_rtc) begin miscompares++; $display("FAIL clamp tick e=%0d: got %b expected %b", e, tick, exp_rtc); end
        end
        vectors++; if (tick_count !== 4'd4) begin miscompares++; $display("FAIL clamp count: got %0d expected 4", tick_count); end
    endtask

    // hp=1, 17 rises: count 15 at edge 29, 0 at 31, 1 at 33.
    task automatic test_wrap();
        logic [CNT_W-1:0] exp_cnt;
        apply_reset();
        config_in_stop(16'd1);
        run = 1'b1;
        for (int e = 0; e <= 33; e++) begin
            step();
            exp_cnt = CNT_W'((e + 1) / 2);
            vectors++; if (tick_count !== exp_cnt) begin miscompares++; $display("FAIL wrap count e=%0d: got %0d expected %0d", e, tick_count, exp_cnt); end
        end
    endtask

    // Reset mid high phase with a value pending and valid asserted.
    task automatic test_reset_mid();
        logic exp_rtc;
        apply_reset();
        run = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            cfg_if.cfg_valid_i   = (e == 10);
            cfg_if.half_period_i = 16'd3;
            step();
        end
        vectors++; if (cfg_if.cfg_ready_o !== 1'b0) begin miscompares++; $display("FAIL rmid pend ready: got %b expected 0", cfg_if.cfg_ready_o); end
        arst_n               = 1'b0;
        cfg_if.cfg_valid_i   = 1'b1;
        cfg_if.half_period_i = 16'd5;
        step();
        cfg_if.cfg_valid_i = 1'b0;
        arst_n             = 1'b1;
        vectors++; if (rtc !== 1'b0) begin miscompares++; $display("FAIL rmid rtc: got %b expected 0", rtc); end
        vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL rmid tick: got %b expected 0", tick); end
        vectors++; if (tick_count !== 4'd0) begin miscompares++; $display("FAIL rmid count: got %0d expected 0", tick_count); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL rmid running: got %b expected 0", running); end
        vectors++; if (cfg_if.cfg_ready_o !== 1'b1) begin miscompares++; $display("FAIL rmid ready: got %b expected 1", cfg_if.cfg_ready_o); end
        for (int e = 0; e <= 8; e++) begin
            step();
            exp_rtc = (e >= 8);
            vectors++; if (rtc !== exp_rtc) begin miscompares++; $display("FAIL rmid hp rtc e=%0d: got %b expected %b", e, rtc, exp_rtc); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_cfg_change();
        test_drain_stop();
        test_drain_resume();
        test_clamp();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
